mips16_load_ctrl: RTL and testbench
===================================

MIPS16_LOAD_CTRL -- requirements
Module: mips16_load_ctrl

Interface
REQ-001 The block SHALL have the parameter ADDR_W, default 8, giving the instruction-memory word-address width.
REQ-002 The block SHALL have the following ports:
- clk  in  1  single clock, all state on rising edge
- rst  in  1  reset, synchronous, active-high
- byte_in  in  8  host command/data byte
- byte_valid  in  1  byte_in valid
- byte_ready  out  1  block accepts byte_in this cycle
- imem_we  out  1  instruction-memory write strobe
- imem_addr  out  ADDR_W  write word address
- imem_wdata  out  16  write instruction word
- core_pc  in  ADDR_W  current core PC
- core_en  out  1  core advance enable (one instruction per cycle high)
- core_rst  out  1  core reset hold
- busy  out  1  state != IDLE
- running  out  1  state == RUN
- err  out  1  sticky protocol error

Function
REQ-003 A byte SHALL transfer only in a cycle where byte_valid && byte_ready are both high.
REQ-004 The opcodes SHALL be: 0x00 CLR_ERR, 0x01 LOAD, 0x02 RUN, 0x03 STEP, 0x04 HALT, 0x05 CORE_RST, 0x06 SET_BRK, 0x07 CLR_BRK.
REQ-005 The states SHALL be IDLE, L_ADDR, L_CNT, L_HI, L_LO, WRITE, RUN, STEP, B_ADDR.
REQ-006 byte_ready SHALL be 1 in IDLE, L_ADDR, L_CNT, L_HI, L_LO, B_ADDR and RUN, and 0 in WRITE and STEP.
REQ-007 LOAD SHALL follow this sequence:
- IDLE->L_ADDR on opcode; the accepted address byte loads the address pointer, then ->L_CNT.
- The count byte N is latched; N=0 returns to IDLE with no write, otherwise ->L_HI.
- L_HI takes the high byte, then ->L_LO takes the low byte, then ->WRITE.
REQ-008 WRITE SHALL last exactly one cycle with imem_we=1, imem_addr=pointer and imem_wdata={hi,lo}.
REQ-009 On leaving WRITE, the pointer SHALL increment modulo 2^ADDR_W (wrapping 255->0 at the default) and N SHALL decrement; N=0 ->IDLE, else ->L_HI.
REQ-010 A LOAD SHALL write exactly N words, with every write latency one cycle after the low byte is accepted.
REQ-011 RUN (IDLE->RUN) SHALL clear core_rst and assert core_en every cycle while in RUN.
REQ-012 In RUN, accepting 0x04 SHALL drop core_en in the same cycle and move to IDLE next cycle.
REQ-013 In RUN, any other accepted byte SHALL be discarded and SHALL set err, with no state change.
REQ-014 Breakpoint: when brk_en && core_pc==brk_addr in RUN, core_en SHALL be 0 that cycle and the state SHALL move to IDLE.
REQ-015 The breakpoint compare SHALL be suppressed in the first RUN cycle, so RUN resumes past a breakpoint.
REQ-016 STEP (IDLE->STEP) SHALL clear core_rst, assert core_en for exactly one cycle, then go to IDLE; breakpoints SHALL be ignored.
REQ-017 CORE_RST SHALL set core_rst=1, held until the next RUN or STEP.
REQ-018 SET_BRK SHALL go ->B_ADDR; the next byte SHALL load brk_addr, set brk_en=1, then ->IDLE.
REQ-019 CLR_BRK SHALL clear brk_en.
REQ-020 HALT received in IDLE SHALL be a no-op.
REQ-021 An unknown opcode (>0x07) in IDLE SHALL set err and stay in IDLE.
REQ-022 CLR_ERR SHALL clear err; if err is set and cleared in the same cycle, set SHALL win.
REQ-023 core_en SHALL be 0 whenever core_rst=1 and in every state except RUN/STEP.
REQ-024 imem_we SHALL be high only in WRITE.

Reset
REQ-025 On rst=1 at a clock edge, the block SHALL go to IDLE and set:
- byte_ready=1 (from first post-reset cycle)
- imem_we=0, imem_addr=0, imem_wdata=0
- core_en=0, core_rst=1
- busy=0, running=0, err=0, brk_en=0, brk_addr=0, N=0
REQ-026 Reset mid-LOAD or mid-RUN SHALL abandon the operation immediately, with no further imem_we or core_en.
REQ-027 Reset SHALL take priority over every other event in the same cycle.

Structure
REQ-028 Opcode constants, the state enumeration and the ADDR_W default SHALL live in shared package mips16_pkg.
REQ-029 The block SHALL be a single FSM module; no sub-module is required.
REQ-030 core_en and byte_ready SHALL be combinational from state and inputs; all other outputs SHALL be registered.

Verification
REQ-031 Bytes 01 10 02 12 34 AB CD SHALL give imem_we pulses writing 0x1234@0x10 then 0xABCD@0x11, with byte_ready=0 on each WRITE cycle.
REQ-032 Bytes 01 FF 02 00 01 00 02 SHALL give writes 0x0001@0xFF then 0x0002@0x00 (wrap).
REQ-033 Bytes 06 05 then 02, with core_pc advancing 0..5, SHALL give core_en high for PCs 0-4 and low at PC 5, state IDLE; a second 02 SHALL give core_en high in the first cycle.
REQ-034 Bytes 05 then 03 SHALL give core_rst high until the STEP cycle and exactly one core_en pulse.
REQ-035 Byte 02 then 09 during RUN SHALL set err=1 with running=1; 04 SHALL then stop the core and 00 SHALL clear err.
REQ-036 rst asserted after byte 01 10 02 12 SHALL give no imem_we; all outputs take their reset values next cycle and core_rst=1.

Source files
------------

// File: rtl/mips16_pkg.sv
// ============================================================================
// Module      : mips16_pkg
// Description : Shared opcodes, FSM state encoding and default widths for the
//               MIPS16 host load/debug controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mips16_pkg;

    localparam int C_ADDR_W = 8;

    localparam logic [7:0] C_OP_CLR_ERR  = 8'h00;
    localparam logic [7:0] C_OP_LOAD     = 8'h01;
    localparam logic [7:0] C_OP_RUN      = 8'h02;
    localparam logic [7:0] C_OP_STEP     = 8'h03;
    localparam logic [7:0] C_OP_HALT     = 8'h04;
    localparam logic [7:0] C_OP_CORE_RST = 8'h05;
    localparam logic [7:0] C_OP_SET_BRK  = 8'h06;
    localparam logic [7:0] C_OP_CLR_BRK  = 8'h07;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_L_ADDR = 4'd1,
        S_L_CNT  = 4'd2,
        S_L_HI   = 4'd3,
        S_L_LO   = 4'd4,
        S_WRITE  = 4'd5,
        S_RUN    = 4'd6,
        S_STEP   = 4'd7,
        S_B_ADDR = 4'd8
    } state_e;

endpackage

`default_nettype wire

// File: rtl/mips16_load_ctrl.sv
// ============================================================================
// Module      : mips16_load_ctrl
// Description : Byte-stream command decoder that loads instruction memory and
//               runs, steps, halts and breakpoints a MIPS16 core.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mips16_load_ctrl
    import mips16_pkg::*;
#(
    parameter int ADDR_W = C_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [15:0]       imem_wdata,
    input  logic [ADDR_W-1:0] core_pc,
    output logic              core_en,
    output logic              core_rst,
    output logic              busy,
    output logic              running,
    output logic              err
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W-1:0] brk_addr_q, brk_addr_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [7:0]        hi_q, hi_d;
    logic [15:0]       wdata_q, wdata_d;
    logic              brk_en_q, brk_en_d;
    logic              core_rst_q, core_rst_d;
    logic              err_q, err_d;
    logic              we_q, busy_q, running_q, first_q;

    logic w_accept, w_halt_now, w_brk_hit, w_err_set, w_err_clr;

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        brk_addr_d = brk_addr_q;
        cnt_d      = cnt_q;
        hi_d       = hi_q;
        wdata_d    = wdata_q;
        brk_en_d   = brk_en_q;
        core_rst_d = core_rst_q;
        w_err_set  = 1'b0;
        w_err_clr  = 1'b0;

        byte_ready = (state_q != S_WRITE) && (state_q != S_STEP);
        w_accept   = byte_valid && byte_ready;
        w_halt_now = (state_q == S_RUN) && w_accept && (byte_in == C_OP_HALT);
        // The first RUN cycle skips the compare so a resumed core can leave
        // the instruction it stopped on.
        w_brk_hit  = (state_q == S_RUN) && brk_en_q && !first_q &&
                     (core_pc == brk_addr_q);
        core_en    = !rst && !core_rst_q &&
                     (((state_q == S_RUN) && !w_halt_now && !w_brk_hit) ||
                      (state_q == S_STEP));

        case (state_q)
            S_IDLE: begin
                if (w_accept) begin
                    case (byte_in)
                        C_OP_CLR_ERR:  w_err_clr = 1'b1;
                        C_OP_LOAD:     state_d = S_L_ADDR;
                        C_OP_RUN: begin
                            state_d    = S_RUN;
                            core_rst_d = 1'b0;
                        end
                        C_OP_STEP: begin
                            state_d    = S_STEP;
                            core_rst_d = 1'b0;
                        end
                        C_OP_HALT:     ;
                        C_OP_CORE_RST: core_rst_d = 1'b1;
                        C_OP_SET_BRK:  state_d = S_B_ADDR;
                        C_OP_CLR_BRK:  brk_en_d = 1'b0;
                        default:       w_err_set = 1'b1;
                    endcase
                end
            end
            S_L_ADDR: begin
                if (w_accept) begin
                    ptr_d   = ADDR_W'(byte_in);
                    state_d = S_L_CNT;
                end
            end
            S_L_CNT: begin
                if (w_accept) begin
                    cnt_d   = byte_in;
                    state_d = (byte_in == 8'd0) ? S_IDLE : S_L_HI;
                end
            end
            S_L_HI: begin
                if (w_accept) begin
                    hi_d    = byte_in;
                    state_d = S_L_LO;
                end
            end
            S_L_LO: begin
                if (w_accept) begin
                    wdata_d = {hi_q, byte_in};
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                ptr_d   = ptr_q + ADDR_W'(1);
                cnt_d   = cnt_q - 8'd1;
                state_d = (cnt_q == 8'd1) ? S_IDLE : S_L_HI;
            end
            S_RUN: begin
                if (w_accept && !w_halt_now) begin
                    w_err_set = 1'b1;
                end
                if (w_halt_now || w_brk_hit) begin
                    state_d = S_IDLE;
                end
            end
            S_STEP:   state_d = S_IDLE;
            S_B_ADDR: begin
                if (w_accept) begin
                    brk_addr_d = ADDR_W'(byte_in);
                    brk_en_d   = 1'b1;
                    state_d    = S_IDLE;
                end
            end
            default:  state_d = S_IDLE;
        endcase

        err_d = w_err_set ? 1'b1 : (w_err_clr ? 1'b0 : err_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            ptr_q      <= '0;
            brk_addr_q <= '0;
            cnt_q      <= 8'd0;
            hi_q       <= 8'd0;
            wdata_q    <= 16'd0;
            brk_en_q   <= 1'b0;
            core_rst_q <= 1'b1;
            err_q      <= 1'b0;
            we_q       <= 1'b0;
            busy_q     <= 1'b0;
            running_q  <= 1'b0;
            first_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            brk_addr_q <= brk_addr_d;
            cnt_q      <= cnt_d;
            hi_q       <= hi_d;
            wdata_q    <= wdata_d;
            brk_en_q   <= brk_en_d;
            core_rst_q <= core_rst_d;
            err_q      <= err_d;
            we_q       <= (state_d == S_WRITE);
            busy_q     <= (state_d != S_IDLE);
            running_q  <= (state_d == S_RUN);
            first_q    <= (state_d == S_RUN) && (state_q != S_RUN);
        end
    end

    assign imem_we    = we_q;
    assign imem_addr  = ptr_q;
    assign imem_wdata = wdata_q;
    assign core_rst   = core_rst_q;
    assign busy       = busy_q;
    assign running    = running_q;
    assign err        = err_q;

endmodule

`default_nettype wire

// File: tb/tb_mips16_load_ctrl.sv
// ============================================================================
// Module      : tb_mips16_load_ctrl
// Description : Self-checking bench: table-driven LOAD vectors with a write
//               scoreboard, plus run/step/breakpoint/error/reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mips16_load_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic        imem_we;
    logic [7:0]  imem_addr;
    logic [15:0] imem_wdata;
    logic [7:0]  core_pc;
    logic        core_en;
    logic        core_rst;
    logic        busy;
    logic        running;
    logic        err;
    logic        pc_load;

    int n_checks = 0;
    int n_pass   = 0;

    logic [23:0] exp_q[$];

    typedef struct {
        logic [7:0]       addr;
        logic [7:0]       n;
        logic [3:0][15:0] w;
    } vec_t;

    vec_t vecs[5];

    mips16_load_ctrl #(.ADDR_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .core_pc    (core_pc),
        .core_en    (core_en),
        .core_rst   (core_rst),
        .busy       (busy),
        .running    (running),
        .err        (err)
    );

    always #5 clk = ~clk;

    // Simple core model: PC advances once per enabled cycle.
    always @(posedge clk) begin
        if (pc_load)      core_pc <= 8'd0;
        else if (core_en) core_pc <= core_pc + 8'd1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Presents a byte at a negedge and holds it until accepted; returns at
    // the negedge following the accepting rising edge.
    task automatic send(input logic [7:0] b);
        int t = 0;
        byte_in    = b;
        byte_valid = 1'b1;
        while (!byte_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (t >= 20) check("send_timeout", 32'(t), 32'd0);
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    // Write scoreboard: every imem_we pulse must match the oldest expected write.
    always @(negedge clk) begin
        logic [23:0] e;
        #1;
        if (!rst && imem_we) begin
            if (exp_q.size() == 0) begin
                check("unexpected_we", 32'(imem_we), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("we_addr",  32'(imem_addr),  32'(e[23:16]));
                check("we_data",  32'(imem_wdata), 32'(e[15:0]));
                check("we_ready", 32'(byte_ready), 32'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] a;
        logic [7:0] pc0;

        vecs[0] = '{addr: 8'h10, n: 8'd2, w: {16'h0, 16'h0, 16'hABCD, 16'h1234}};
        vecs[1] = '{addr: 8'hFF, n: 8'd2, w: {16'h0, 16'h0, 16'h0002, 16'h0001}};
        vecs[2] = '{addr: 8'h20, n: 8'd0, w: {16'h0, 16'h0, 16'h0, 16'h0}};
        vecs[3] = '{addr: 8'h80, n: 8'd3, w: {16'h0, 16'hC0DE, 16'h5A5A, 16'hFFFF}};
        vecs[4] = '{addr: 8'h7F, n: 8'd1, w: {16'h0, 16'h0, 16'h0, 16'h8001}};

        rst = 1'b1; byte_in = 8'h00; byte_valid = 1'b0; pc_load = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0; pc_load = 1'b0;

        check("rst_byte_ready", 32'(byte_ready), 32'd1);
        check("rst_imem_we",    32'(imem_we),    32'd0);
        check("rst_imem_addr",  32'(imem_addr),  32'd0);
        check("rst_imem_wdata", 32'(imem_wdata), 32'd0);
        check("rst_core_en",    32'(core_en),    32'd0);
        check("rst_core_rst",   32'(core_rst),   32'd1);
        check("rst_busy",       32'(busy),       32'd0);
        check("rst_running",    32'(running),    32'd0);
        check("rst_err",        32'(err),        32'd0);

        // Table-driven LOAD transactions
        for (int i = 0; i < 5; i++) begin
            send(8'h01);
            check("load_busy", 32'(busy), 32'd1);
            send(vecs[i].addr);
            send(vecs[i].n);
            for (int k = 0; k < int'(vecs[i].n); k++) begin
                a = vecs[i].addr + 8'(k);
                exp_q.push_back({a, vecs[i].w[k]});
                send(vecs[i].w[k][15:8]);
                send(vecs[i].w[k][7:0]);
            end
            repeat (2) @(negedge clk);
            check("load_drained", 32'(exp_q.size()), 32'd0);
            check("load_idle",    32'(busy),         32'd0);
        end

        // Breakpoint at PC 5, run from PC 0
        send(8'h06);
        send(8'h05);
        check("brk_setup_idle", 32'(busy), 32'd0);
        send(8'h02);
        for (int i = 0; i <= 5; i++) begin
            check("brk_pc",      32'(core_pc), 32'(i));
            check("brk_core_en", 32'(core_en), (i < 5) ? 32'd1 : 32'd0);
            @(negedge clk);
        end
        check("brk_stopped", 32'(running), 32'd0);
        check("brk_idle",    32'(busy),    32'd0);
        check("brk_hold_en", 32'(core_en), 32'd0);
        send(8'h02);
        check("resume_en",      32'(core_en), 32'd1);
        check("resume_running", 32'(running), 32'd1);
        @(negedge clk);
        check("resume_past", 32'(core_pc), 32'd6);
        byte_in = 8'h04; byte_valid = 1'b1;
        #1;
        check("halt_same_cycle", 32'(core_en), 32'd0);
        @(negedge clk);
        byte_valid = 1'b0;
        check("halt_running", 32'(running), 32'd0);
        check("halt_busy",    32'(busy),    32'd0);
        send(8'h07);

        // CORE_RST then STEP, with a breakpoint on the current PC
        send(8'h05);
        check("crst_core_rst", 32'(core_rst), 32'd1);
        check("crst_core_en",  32'(core_en),  32'd0);
        pc0 = core_pc;
        send(8'h06);
        send(pc0);
        @(negedge clk);
        check("crst_held", 32'(core_rst), 32'd1);
        send(8'h03);
        check("step_core_rst", 32'(core_rst),   32'd0);
        check("step_core_en",  32'(core_en),    32'd1);
        check("step_ready",    32'(byte_ready), 32'd0);
        @(negedge clk);
        check("step_done_en", 32'(core_en), 32'd0);
        check("step_one_pc",  32'(core_pc), 32'(pc0 + 8'd1));
        check("step_idle",    32'(busy),    32'd0);
        send(8'h07);

        // Errors: stray byte in RUN, unknown opcode in IDLE, HALT no-op in IDLE
        send(8'h02);
        send(8'h09);
        check("run_err",     32'(err),     32'd1);
        check("run_err_run", 32'(running), 32'd1);
        send(8'h04);
        check("run_err_halt", 32'(core_en), 32'd0);
        check("run_err_idle", 32'(running), 32'd0);
        check("err_sticky",   32'(err),     32'd1);
        send(8'h00);
        check("err_cleared", 32'(err), 32'd0);
        send(8'h42);
        check("unk_err",  32'(err),  32'd1);
        check("unk_idle", 32'(busy), 32'd0);
        send(8'h00);
        send(8'h04);
        check("halt_idle_noop_err",  32'(err),  32'd0);
        check("halt_idle_noop_busy", 32'(busy), 32'd0);

        // Reset in the middle of a LOAD word: no write may follow
        send(8'h01);
        send(8'h10);
        send(8'h02);
        send(8'h12);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mrst_we",       32'(imem_we),   32'd0);
        check("mrst_addr",     32'(imem_addr), 32'd0);
        check("mrst_busy",     32'(busy),      32'd0);
        check("mrst_core_rst", 32'(core_rst),  32'd1);
        send(8'h34);
        repeat (3) @(negedge clk);
        check("mrst_no_load", 32'(busy), 32'd0);

        // Reset while running: core_en must drop right after the edge
        send(8'h02);
        check("mrun_en", 32'(core_en), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mrun_rst_en",      32'(core_en), 32'd0);
        check("mrun_rst_running", 32'(running), 32'd0);
        check("mrun_rst_err",     32'(err),     32'd0);
        repeat (2) @(negedge clk);
        check("mrun_rst_hold", 32'(core_en), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
